// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_pkg: access-size encodings, stage FSM states, byte-enable LUT  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Access width in bytes minus one; a dword on a 32-bit datapath acts as a word.
  function automatic logic [2:0] size_mask(input logic [1:0] size, input logic is64);
    logic [2:0] m;
    case (size)
      SZ_BYTE: m = 3'd0;
      SZ_HALF: m = 3'd1;
      SZ_WORD: m = 3'd3;
      default: m = is64 ? 3'd7 : 3'd3;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] be_lookup(input logic [1:0] size, input logic [2:0] offs,
                                           input logic is64);
    logic [2:0] m;
    logic [7:0] lanes;
    m     = size_mask(size, is64);
    lanes = 8'((9'd2 << m) - 9'd1);
    return lanes << (offs & ~m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align: lane-shifts a raw read word and sign/zero-extends sub-words  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            i_rdata,
  input  logic [$clog2(XLEN/8)-1:0]  i_addr_low,
  input  logic [1:0]                 i_size,
  input  logic                       i_sign,
  output logic [XLEN-1:0]            o_data
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_keep;
  logic            w_msb;

  assign w_shifted = i_rdata >> {i_addr_low, 3'b000};

  always_comb begin
    w_keep = '1;
    w_msb  = w_shifted[XLEN-1];
    case (i_size)
      SZ_BYTE: begin
        w_keep = XLEN'(8'hFF);
        w_msb  = w_shifted[7];
      end
      SZ_HALF: begin
        w_keep = XLEN'(16'hFFFF);
        w_msb  = w_shifted[15];
      end
      SZ_WORD: begin
        w_keep = XLEN'(32'hFFFF_FFFF);
        w_msb  = w_shifted[31];
      end
      default: ;
    endcase
  end

  assign o_data = (w_shifted & w_keep) | ((i_sign && w_msb) ? ~w_keep : '0);

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_ctrl: handshaked multi-cycle EX->WB memory stage (req/ack dmem) |
// | Option: MEM_MISALIGN_CHECK_EN rejects misaligned accesses with err.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_wEn,
  input  logic              mem_rEn,
  input  logic              load_extend_sign,
  input  logic              branch_op,
  input  logic              jump_flag,
  input  logic [1:0]        MemSize,
  input  logic [XLEN-1:0]   PC,
  input  logic [XLEN-1:0]   imm32,
  input  logic [XLEN-1:0]   Rdata2,
  input  logic [XLEN-1:0]   ALU_result,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   DataWord,
  output logic [XLEN-1:0]   alu_out,
  output logic              npc_control,
  output logic [XLEN-1:0]   npc_target,
  output logic              err
);

  localparam int               c_NB   = XLEN / 8;
  localparam int               c_OFFW = $clog2(c_NB);
  localparam logic             c_IS64 = (XLEN == 64);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MAX_WAIT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [c_NB-1:0]   r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_data;
  logic [XLEN-1:0]   r_alu;
  logic              r_npc_ctrl;
  logic [XLEN-1:0]   r_npc_tgt;
  logic              r_err;
  logic [c_OFFW-1:0] r_offs;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_is_load;

  logic              w_mem_op;
  logic              w_reject;
  logic              w_timeout;
  logic [2:0]        w_mask;
  logic [2:0]        w_offs;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_load_data;

  assign w_mem_op = mem_wEn | mem_rEn;
  assign w_mask   = size_mask(MemSize, c_IS64);
  // Misaligned low bits are dropped, so the access lands on the natural boundary.
  assign w_offs   = 3'(ALU_result[c_OFFW-1:0]) & ~w_mask;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_reject = w_mem_op & (|(3'(ALU_result[c_OFFW-1:0]) & w_mask));
`else
  assign w_reject = 1'b0;
`endif

  assign w_timeout = (r_state == ST_REQ) & ~dmem_ack & (r_cnt == c_LAST);

  // Store data repeated across every lane group of the access width.
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < c_NB; i++) begin
      w_wdata[8*i +: 8] = Rdata2[8*(i & int'(w_mask)) +: 8];
    end
  end

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_rdata    (dmem_rdata),
    .i_addr_low (r_offs),
    .i_size     (r_size),
    .i_sign     (r_sign),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)              w_state_nxt = (w_mem_op && !w_reject) ? ST_REQ : ST_RESP;
      ST_REQ:  if (dmem_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: if (out_ready)             w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_alu      <= '0;
      r_npc_ctrl <= 1'b0;
      r_npc_tgt  <= '0;
      r_err      <= 1'b0;
      r_offs     <= '0;
      r_size     <= '0;
      r_sign     <= 1'b0;
      r_is_load  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_alu      <= ALU_result;
            r_npc_ctrl <= jump_flag | (branch_op & ALU_result[0]);
            r_npc_tgt  <= jump_flag ? {ALU_result[XLEN-1:1], 1'b0} : PC + imm32;
            r_data     <= '0;
            r_err      <= w_reject;
            r_cnt      <= '0;
            r_offs     <= c_OFFW'(w_offs);
            r_size     <= MemSize;
            r_sign     <= load_extend_sign;
            r_is_load  <= mem_rEn & ~mem_wEn;
            if (w_mem_op && !w_reject) begin
              r_we    <= mem_wEn;
              r_be    <= c_NB'(be_lookup(MemSize, w_offs, c_IS64));
              r_addr  <= {ALU_result[XLEN-1:c_OFFW], c_OFFW'(0)};
              r_wdata <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (dmem_ack) begin
            r_data <= r_is_load ? w_load_data : '0;
            r_we   <= 1'b0;
            r_be   <= '0;
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_data <= '0;
            r_we   <= 1'b0;
            r_be   <= '0;
          end
        end
        ST_RESP: begin
          if (out_ready) r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign dmem_req    = (r_state == ST_REQ);
  assign out_valid   = (r_state == ST_RESP);
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_be     = r_be;
  assign dmem_wdata  = r_wdata;
  assign DataWord    = r_data;
  assign alu_out     = r_alu;
  assign npc_control = r_npc_ctrl;
  assign npc_target  = r_npc_tgt;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage_ctrl: directed and random checks of mem_stage_ctrl          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_stage_ctrl;

  localparam int MAX_WAIT = 255;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, mem_wEn, mem_rEn, load_extend_sign;
  logic        branch_op, jump_flag, dmem_req, dmem_we, dmem_ack, out_valid, out_ready;
  logic        npc_control, err;
  logic [1:0]  MemSize;
  logic [31:0] PC, imm32, Rdata2, ALU_result, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] DataWord, alu_out, npc_target;
  logic [3:0]  dmem_be;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage_ctrl #(.XLEN(32), .MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wEn(mem_wEn), .mem_rEn(mem_rEn), .load_extend_sign(load_extend_sign),
    .branch_op(branch_op), .jump_flag(jump_flag), .MemSize(MemSize),
    .PC(PC), .imm32(imm32), .Rdata2(Rdata2), .ALU_result(ALU_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .DataWord(DataWord),
    .alu_out(alu_out), .npc_control(npc_control), .npc_target(npc_target), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    return 4'(((1 << nbytes(sz)) - 1) << lane_off(sz, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (nbytes(sz))
      1:       return {4{d[7:0]}};
      2:       return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic [31:0] rd, input logic sg);
    int n = nbytes(sz);
    logic [31:0] v, keep;
    v = rd >> (8 * lane_off(sz, a));
    if (n == 4) return v;
    keep = (32'h1 << (8 * n)) - 32'h1;
    v = v & keep;
    if (sg && v[8*n-1]) v = v | ~keep;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic we, input logic re, input logic sg, input logic br,
                       input logic jp, input logic [1:0] sz, input logic [31:0] pc,
                       input logic [31:0] im, input logic [31:0] d2, input logic [31:0] alu);
    mem_wEn = we; mem_rEn = re; load_extend_sign = sg; branch_op = br; jump_flag = jp;
    MemSize = sz; PC = pc; imm32 = im; Rdata2 = d2; ALU_result = alu; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_wEn = 1'b0; mem_rEn = 1'b0; branch_op = 1'b0; jump_flag = 1'b0;
    ALU_result = $urandom; Rdata2 = $urandom;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 0; mem_wEn = 0; mem_rEn = 0; load_extend_sign = 0;
    branch_op = 0; jump_flag = 0; MemSize = 0; PC = 0; imm32 = 0; Rdata2 = 0;
    ALU_result = 0; dmem_ack = 0; dmem_rdata = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, dmem_req, dmem_we, out_valid, err, npc_control} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b expected 100000",
               {in_ready, dmem_req, dmem_we, out_valid, err, npc_control});
    else n_pass++;
    n_checks++;
    if ({dmem_be, dmem_addr, dmem_wdata, DataWord, alu_out, npc_target} !== '0)
      $display("FAIL reset_data: got be=%h addr=%h wd=%h dw=%h alu=%h tgt=%h expected all 0",
               dmem_be, dmem_addr, dmem_wdata, DataWord, alu_out, npc_target);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_jump();
    issue(0, 0, 0, 0, 1, 2'b10, 32'h40, 32'h10, 32'h0, 32'h1003);
    n_checks++;
    if ({out_valid, in_ready, dmem_req, npc_control, err} !== 5'b10010)
      $display("FAIL jump_ctrl: got %b expected 10010",
               {out_valid, in_ready, dmem_req, npc_control, err});
    else n_pass++;
    n_checks++;
    if (npc_target !== 32'h1002) $display("FAIL jump_target: got %h expected 00001002", npc_target);
    else n_pass++;
    n_checks++;
    if ({alu_out, DataWord} !== {32'h1003, 32'h0})
      $display("FAIL jump_data: got alu=%h dw=%h expected 00001003 00000000", alu_out, DataWord);
    else n_pass++;
    retire();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL jump_retire: got %b expected 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_load_byte();
    issue(0, 1, 1, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h103);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1000, 32'h100})
      $display("FAIL lb_req: got req=%b we=%b be=%b addr=%h expected 1 0 1000 00000100",
               dmem_req, dmem_we, dmem_be, dmem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dmem_req, out_valid} !== 2'b10)
        $display("FAIL lb_hold: got req/valid=%b expected 10", {dmem_req, out_valid});
      else n_pass++;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF00;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    n_checks++;
    if ({out_valid, dmem_req, err} !== 3'b100)
      $display("FAIL lb_valid: got %b expected 100", {out_valid, dmem_req, err});
    else n_pass++;
    n_checks++;
    if (DataWord !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h expected ffffff80", DataWord);
    else n_pass++;
    retire();
  endtask

  task automatic test_store_half();
    issue(1, 0, 0, 0, 0, 2'b01, 32'h0, 32'h0, 32'h0000_ABCD, 32'h202);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b1, 4'b1100, 32'h200})
        $display("FAIL sh_req: got req=%b we=%b be=%b addr=%h expected 1 1 1100 00000200",
                 dmem_req, dmem_we, dmem_be, dmem_addr);
      else n_pass++;
      if (i < 3) @(negedge clk);
    end
    n_checks++;
    if (dmem_wdata[31:16] !== 16'hABCD)
      $display("FAIL sh_wdata: got %h expected abcd", dmem_wdata[31:16]);
    else n_pass++;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if ({out_valid, dmem_req, dmem_we, DataWord} !== {3'b100, 32'h0})
      $display("FAIL sh_done: got valid=%b req=%b we=%b dw=%h expected 1 0 0 00000000",
               out_valid, dmem_req, dmem_we, DataWord);
    else n_pass++;
    retire();
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(0, 1, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h300);
    while (dmem_req === 1'b1 && n < MAX_WAIT + 20) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== MAX_WAIT) $display("FAIL timeout_len: got %0d req cycles expected %0d", n, MAX_WAIT);
    else n_pass++;
    n_checks++;
    if ({out_valid, err, dmem_req, DataWord} !== {3'b110, 32'h0})
      $display("FAIL timeout_resp: got valid=%b err=%b req=%b dw=%h expected 1 1 0 00000000",
               out_valid, err, dmem_req, DataWord);
    else n_pass++;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if ({out_valid, err, DataWord} !== {2'b11, 32'h0})
      $display("FAIL stray_ack: got valid=%b err=%b dw=%h expected 1 1 00000000",
               out_valid, err, DataWord);
    else n_pass++;
    retire();
    n_checks++;
    if ({out_valid, err, in_ready} !== 3'b001)
      $display("FAIL timeout_clear: got %b expected 001", {out_valid, err, in_ready});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a = $urandom;
    issue(0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, a);
    in_valid = 1'b1; ALU_result = ~a;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, alu_out} !== {2'b10, a})
        $display("FAIL bp_hold: got valid=%b rdy=%b alu=%h expected 1 0 %h",
                 out_valid, in_ready, alu_out, a);
      else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    retire();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_release: got %b expected 01", {out_valid, in_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_single: got %b expected 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    issue(0, 1, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h400);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({dmem_req, in_ready, out_valid, err} !== 4'b0100)
      $display("FAIL rst_mid: got %b expected 0100", {dmem_req, in_ready, out_valid, err});
    else n_pass++;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if ({dmem_req, in_ready, out_valid} !== 3'b010)
      $display("FAIL rst_ack: got %b expected 010", {dmem_req, in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_misalign();
    logic [31:0] rd = $urandom;
    issue(0, 1, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h101);
`ifdef MEM_MISALIGN_CHECK_EN
    n_checks++;
    if ({dmem_req, out_valid, err, DataWord} !== {3'b011, 32'h0})
      $display("FAIL misalign_err: got req=%b valid=%b err=%b dw=%h expected 0 1 1 00000000",
               dmem_req, out_valid, err, DataWord);
    else n_pass++;
`else
    n_checks++;
    if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'hF, 32'h100})
      $display("FAIL misalign_trunc: got req=%b be=%b addr=%h expected 1 1111 00000100",
               dmem_req, dmem_be, dmem_addr);
    else n_pass++;
    dmem_ack = 1'b1; dmem_rdata = rd;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++;
    if ({out_valid, err, DataWord} !== {2'b10, rd})
      $display("FAIL misalign_load: got valid=%b err=%b dw=%h expected 1 0 %h",
               out_valid, err, DataWord, rd);
    else n_pass++;
`endif
    retire();
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int          kind = $urandom_range(0, 5);
      logic [1:0]  sz   = 2'($urandom_range(0, 2));
      logic [31:0] pc = $urandom, im = $urandom, d2 = $urandom, alu = $urandom, rd = $urandom;
      logic        sg = 1'($urandom), we, re, br, jp, exp_npc;
      logic [31:0] exp_dw;
      we = (kind == 4) || (kind == 5);
      re = (kind == 3) || (kind == 5);
      br = (kind == 2);
      jp = (kind == 1);
`ifdef MEM_MISALIGN_CHECK_EN
      if (we || re) alu = alu & ~32'(nbytes(sz) - 1);
`endif
      exp_npc = jp | (br & alu[0]);
      exp_dw  = (re && !we) ? m_load(sz, alu, rd, sg) : 32'h0;
      issue(we, re, sg, br, jp, sz, pc, im, d2, alu);
      if (we || re) begin
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, we, m_be(sz, alu), alu & ~32'h3})
          $display("FAIL rnd_req: got req=%b we=%b be=%b addr=%h expected 1 %b %b %h",
                   dmem_req, dmem_we, dmem_be, dmem_addr, we, m_be(sz, alu), alu & ~32'h3);
        else n_pass++;
        if (we) begin
          n_checks++;
          if (dmem_wdata !== m_wdata(sz, d2))
            $display("FAIL rnd_wdata: got %h expected %h", dmem_wdata, m_wdata(sz, d2));
          else n_pass++;
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      n_checks++;
      if ({out_valid, dmem_req, err, npc_control} !== {3'b100, exp_npc})
        $display("FAIL rnd_ctrl: got valid=%b req=%b err=%b npc=%b expected 1 0 0 %b",
                 out_valid, dmem_req, err, npc_control, exp_npc);
      else n_pass++;
      n_checks++;
      if ({DataWord, alu_out} !== {exp_dw, alu})
        $display("FAIL rnd_data: got dw=%h alu=%h expected %h %h", DataWord, alu_out, exp_dw, alu);
      else n_pass++;
      if (jp || br) begin
        n_checks++;
        if (npc_target !== (jp ? {alu[31:1], 1'b0} : pc + im))
          $display("FAIL rnd_target: got %h expected %h",
                   npc_target, jp ? {alu[31:1], 1'b0} : pc + im);
        else n_pass++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_load_byte();
    test_store_half();
    test_timeout();
    test_backpressure();
    test_rst_mid();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
